write_back: RTL and testbench

//  Final pipeline stage (MEM/WB). Accepts one retiring instruction per cycle from the memory

---
 rtl/write_back.sv | 105 ++++++++++
 tb/tb_write_back.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// MEM/WB retire stage: picks ALU result or load data, drives the register-file write port,
// stalls on slow loads, and keeps a sticky load-timeout flag plus a retire counter.
module write_back #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned R0_WRITABLE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_wb,
  input  logic [31:0]      alu_wb,
  input  logic [4:0]       Ri_wb,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             reg_update,
  output logic [31:0]      reg_i,
  output logic [4:0]       Ri_in,
  output logic             fwd_valid,
  output logic             busy,
  output logic             load_err,
  output logic [CNT_W-1:0] retired_cnt
);
  // state    | meaning
  // IDLE     | nothing in flight, ready to accept
  // WAIT_MEM | load accepted, waiting for mem_ack or timeout; upstream stalled
  // COMMIT   | one-cycle register-file write of the latched result

  localparam int TMO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo;
  logic [4:0]       ri_pend;
  logic             wr_pend;

  logic is_alu, is_lw, wr_ok;

  assign is_alu = (op_wb[5:4] == 2'b00);
  assign is_lw  = (op_wb == 6'b01_0000);
  assign wr_ok  = (R0_WRITABLE != 0) || (Ri_wb != 5'd0);

  assign in_ready = (state != WAIT_MEM);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo         <= '0;
      ri_pend     <= '0;
      wr_pend     <= 1'b0;
      reg_update  <= 1'b0;
      fwd_valid   <= 1'b0;
      reg_i       <= '0;
      Ri_in       <= '0;
      load_err    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      reg_update <= 1'b0;
      fwd_valid  <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (state == COMMIT)
            retired_cnt <= retired_cnt + CNT_W'(1);
          if (in_valid) begin
            if (is_lw && !mem_ack) begin
              state   <= WAIT_MEM;
              tmo     <= '0;
              ri_pend <= Ri_wb;
              wr_pend <= wr_ok;
            end else begin
              // load with same-cycle ack commits straight away, like an ALU op
              state      <= COMMIT;
              reg_i      <= is_lw ? mem_rdata : alu_wb;
              Ri_in      <= Ri_wb;
              reg_update <= (is_lw || is_alu) && wr_ok;
              fwd_valid  <= (is_lw || is_alu) && wr_ok;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (mem_ack) begin
            state      <= COMMIT;
            reg_i      <= mem_rdata;
            Ri_in      <= ri_pend;
            reg_update <= wr_pend;
            fwd_valid  <= wr_pend;
          end else if (tmo == TMO_W'(LOAD_TIMEOUT - 1)) begin
            // abandoned load still retires, without a write
            state       <= IDLE;
            load_err    <= 1'b1;
            retired_cnt <= retired_cnt + CNT_W'(1);
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: ALU/LW/no-write retires, load stall and timeout,
// back-to-back commits and reset during a pending load.
module tb_write_back;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op_wb;
  logic [31:0] alu_wb;
  logic [4:0]  Ri_wb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        reg_update;
  logic [31:0] reg_i;
  logic [4:0]  Ri_in;
  logic        fwd_valid;
  logic        busy;
  logic        load_err;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 0;

  localparam logic [5:0] OP_ALU = 6'b00_0000;
  localparam logic [5:0] OP_LW  = 6'b01_0000;
  localparam logic [5:0] OP_SW  = 6'b01_0001;
  localparam logic [5:0] OP_BEQ = 6'b10_0000;
  localparam logic [5:0] OP_JMP = 6'b10_0001;

  write_back #(.LOAD_TIMEOUT(16), .CNT_W(32), .R0_WRITABLE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_wb(op_wb), .alu_wb(alu_wb), .Ri_wb(Ri_wb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .reg_update(reg_update), .reg_i(reg_i), .Ri_in(Ri_in),
    .fwd_valid(fwd_valid), .busy(busy), .load_err(load_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] ri, input logic [31:0] alu);
    in_valid = v; op_wb = op; Ri_wb = ri; alu_wb = alu;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive(1'b0, OP_ALU, 5'd0, 32'd0); mem_ack = 1'b0; mem_rdata = 32'd0;
    #12;
    checks++; if (reg_update !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_upd got upd=%0b fwd=%0b exp 0/0", reg_update, fwd_valid); end
    checks++; if (reg_i !== 32'd0 || Ri_in !== 5'd0) begin errors++; $display("FAIL rst_data got reg_i=%h Ri_in=%0d exp 0/0", reg_i, Ri_in); end
    checks++; if (retired_cnt !== 32'd0 || load_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_misc got cnt=%0d err=%0b busy=%0b rdy=%0b exp 0/0/0/1", retired_cnt, load_err, busy, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    drive(1'b1, OP_ALU, 5'd5, 32'h1234);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || reg_update !== 1'b0) begin errors++; $display("FAIL alu_pre got rdy=%0b upd=%0b exp 1/0", in_ready, reg_update); end
    step(); drive(1'b0, OP_ALU, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (reg_update !== 1'b1 || fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_upd got upd=%0b fwd=%0b exp 1/1", reg_update, fwd_valid); end
    checks++; if (reg_i !== 32'h1234 || Ri_in !== 5'd5) begin errors++; $display("FAIL alu_data got reg_i=%h Ri_in=%0d exp 1234/5", reg_i, Ri_in); end
    step(); exp_cnt++;
    @(negedge clk);
    checks++; if (reg_update !== 1'b0 || busy !== 1'b0 || retired_cnt !== exp_cnt) begin errors++; $display("FAIL alu_post got upd=%0b busy=%0b cnt=%0d exp 0/0/%0d", reg_update, busy, retired_cnt, exp_cnt); end
    checks++; if (reg_i !== 32'h1234 || Ri_in !== 5'd5) begin errors++; $display("FAIL alu_hold got reg_i=%h Ri_in=%0d exp 1234/5", reg_i, Ri_in); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    drive(1'b1, OP_ALU, 5'd1, vals[0]);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, OP_ALU, 5'(i + 2), vals[i+1]);
      else drive(1'b0, OP_ALU, 5'd0, 32'd0);
      @(negedge clk);
      checks++; if (reg_update !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_upd%0d got upd=%0b rdy=%0b exp 1/1", i, reg_update, in_ready); end
      checks++; if (Ri_in !== 5'(i + 1) || reg_i !== vals[i]) begin errors++; $display("FAIL b2b_data%0d got Ri_in=%0d reg_i=%h exp %0d/%h", i, Ri_in, reg_i, i + 1, vals[i]); end
      step();
    end
    exp_cnt += 3;
    @(negedge clk);
    checks++; if (reg_update !== 1'b0 || retired_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_end got upd=%0b cnt=%0d exp 0/%0d", reg_update, retired_cnt, exp_cnt); end
  endtask

  task automatic test_lw_wait();
    drive(1'b1, OP_LW, 5'd7, 32'hFFFF_0000);
    step(); drive(1'b0, OP_ALU, 5'd0, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || reg_update !== 1'b0) begin errors++; $display("FAIL lw_wait%0d got rdy=%0b busy=%0b upd=%0b exp 0/1/0", c, in_ready, busy, reg_update); end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    checks++; if (reg_update !== 1'b1 || reg_i !== 32'hDEAD_BEEF || Ri_in !== 5'd7) begin errors++; $display("FAIL lw_commit got upd=%0b reg_i=%h Ri_in=%0d exp 1/deadbeef/7", reg_update, reg_i, Ri_in); end
    step(); exp_cnt++;
  endtask

  task automatic test_lw_same_cycle();
    drive(1'b1, OP_LW, 5'd9, 32'h0); mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    step(); drive(1'b0, OP_ALU, 5'd0, 32'd0); mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    checks++; if (reg_update !== 1'b1 || reg_i !== 32'hCAFE_0001 || Ri_in !== 5'd9) begin errors++; $display("FAIL lw_fast got upd=%0b reg_i=%h Ri_in=%0d exp 1/cafe0001/9", reg_update, reg_i, Ri_in); end
    step(); exp_cnt++;
    @(negedge clk);
    checks++; if (retired_cnt !== exp_cnt || busy !== 1'b0) begin errors++; $display("FAIL lw_fast_cnt got cnt=%0d busy=%0b exp %0d/0", retired_cnt, busy, exp_cnt); end
  endtask

  task automatic test_timeout();
    int upd_seen = 0;
    drive(1'b1, OP_LW, 5'd4, 32'h0);
    step(); drive(1'b0, OP_ALU, 5'd0, 32'd0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (reg_update !== 1'b0) upd_seen++;
      if (c == 16) begin
        checks++; if (load_err !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL tmo_last got err=%0b rdy=%0b exp 0/0", load_err, in_ready); end
      end
      step();
    end
    exp_cnt++;
    @(negedge clk);
    checks++; if (upd_seen != 0) begin errors++; $display("FAIL tmo_noupd got %0d write cycles exp 0", upd_seen); end
    checks++; if (load_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || reg_update !== 1'b0) begin errors++; $display("FAIL tmo_end got err=%0b busy=%0b rdy=%0b upd=%0b exp 1/0/1/0", load_err, busy, in_ready, reg_update); end
    checks++; if (retired_cnt !== exp_cnt || Ri_in !== 5'd9) begin errors++; $display("FAIL tmo_cnt got cnt=%0d Ri_in=%0d exp %0d/9", retired_cnt, Ri_in, exp_cnt); end
  endtask

  task automatic test_no_write();
    logic [5:0] ops [4] = '{OP_SW, OP_BEQ, OP_ALU, OP_JMP};
    logic [4:0] ris [4] = '{5'd3, 5'd4, 5'd0, 5'd6};
    // stray ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step(); mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || reg_update !== 1'b0) begin errors++; $display("FAIL stray_ack got busy=%0b upd=%0b exp 0/0", busy, reg_update); end
    drive(1'b1, ops[0], ris[0], 32'hAAAA);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, ops[i+1], ris[i+1], 32'hAAAA);
      else drive(1'b1, 6'b00_1111, 5'd31, 32'h0F0F_0F0F);
      @(negedge clk);
      checks++; if (reg_update !== 1'b0 || fwd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nowr%0d got upd=%0b fwd=%0b busy=%0b exp 0/0/1", i, reg_update, fwd_valid, busy); end
      step();
    end
    drive(1'b0, OP_ALU, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (reg_update !== 1'b1 || Ri_in !== 5'd31 || reg_i !== 32'h0F0F_0F0F) begin errors++; $display("FAIL alu_r31 got upd=%0b Ri_in=%0d reg_i=%h exp 1/31/0f0f0f0f", reg_update, Ri_in, reg_i); end
    step(); exp_cnt += 5;
    @(negedge clk);
    checks++; if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL nowr_cnt got %0d exp %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, OP_LW, 5'd6, 32'h0);
    step(); drive(1'b0, OP_ALU, 5'd0, 32'd0);
    step(); step();
    rst_n = 1'b0;
    #2;
    exp_cnt = 0;
    checks++; if (busy !== 1'b0 || load_err !== 1'b0 || retired_cnt !== 32'd0 || reg_i !== 32'd0 || Ri_in !== 5'd0) begin errors++; $display("FAIL rst_mid got busy=%0b err=%0b cnt=%0d reg_i=%h Ri_in=%0d exp all 0", busy, load_err, retired_cnt, reg_i, Ri_in); end
    @(negedge clk); rst_n = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
    step(); mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    checks++; if (reg_update !== 1'b0 || fwd_valid !== 1'b0 || reg_i !== 32'd0 || Ri_in !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL late_ack got upd=%0b fwd=%0b reg_i=%h Ri_in=%0d busy=%0b exp 0/0/0/0/0", reg_update, fwd_valid, reg_i, Ri_in, busy); end
    step();
    @(negedge clk);
    checks++; if (retired_cnt !== exp_cnt || in_ready !== 1'b1) begin errors++; $display("FAIL late_ack_cnt got cnt=%0d rdy=%0b exp %0d/1", retired_cnt, in_ready, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_lw_wait();
    test_lw_same_cycle();
    test_timeout();
    test_no_write();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
